// File: rtl/note_player_pkg.sv
// Shared constants and types for the note player: default widths, waveform codes,
// FSM state encoding and the waveform shaping helper.
package note_player_pkg;

    localparam int SAMPLE_W = 16;
    localparam int PHASE_W  = 24;
    localparam int STEP_W   = 20;
    localparam int DUR_W    = 6;

    localparam logic [1:0] WAVE_SQUARE = 2'b00;
    localparam logic [1:0] WAVE_SAW    = 2'b01;
    localparam logic [1:0] WAVE_TRI    = 2'b10;
    localparam logic [1:0] WAVE_SILENT = 2'b11;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    // Maps the 16-bit waveform index to a full-scale signed sample.
    function automatic logic signed [15:0] wave_sample(input logic [1:0] wave,
                                                       input logic [15:0] p);
        logic [14:0] u;
        logic [15:0] r;
        u = p[15] ? ~p[14:0] : p[14:0];
        r = '0;
        case (wave)
            WAVE_SQUARE: r = p[15] ? 16'hC000 : 16'h3FFF;
            WAVE_SAW:    r = {~p[15], p[14:0]};
            WAVE_TRI:    r = {u, 1'b0} - 16'h8000;
            default:     r = '0;
        endcase
        return signed'(r);
    endfunction

endpackage

// File: rtl/note_player_new_frequency_rom.sv
// Note-index to phase-step table for a 48 kHz sample rate and 24-bit phase
// (step = round(f * 2^24 / 48000), note 37 = A4 = 440 Hz, note 0 = rest).
module frequency_rom
    import note_player_pkg::*;
#(
    parameter int STEP_W = note_player_pkg::STEP_W
) (
    input  logic [5:0]        note_i,
    output logic [STEP_W-1:0] step_o
);

    logic [19:0] raw;

    always_comb begin
        raw = 20'd0;
        case (note_i)
            6'd1:  raw = 20'd19224;   6'd2:  raw = 20'd20367;   6'd3:  raw = 20'd21578;
            6'd4:  raw = 20'd22861;   6'd5:  raw = 20'd24221;   6'd6:  raw = 20'd25661;
            6'd7:  raw = 20'd27187;   6'd8:  raw = 20'd28803;   6'd9:  raw = 20'd30516;
            6'd10: raw = 20'd32331;   6'd11: raw = 20'd34253;   6'd12: raw = 20'd36290;
            6'd13: raw = 20'd38448;   6'd14: raw = 20'd40734;   6'd15: raw = 20'd43156;
            6'd16: raw = 20'd45722;   6'd17: raw = 20'd48441;   6'd18: raw = 20'd51322;
            6'd19: raw = 20'd54373;   6'd20: raw = 20'd57607;   6'd21: raw = 20'd61032;
            6'd22: raw = 20'd64661;   6'd23: raw = 20'd68506;   6'd24: raw = 20'd72580;
            6'd25: raw = 20'd76896;   6'd26: raw = 20'd81468;   6'd27: raw = 20'd86312;
            6'd28: raw = 20'd91445;   6'd29: raw = 20'd96882;   6'd30: raw = 20'd102643;
            6'd31: raw = 20'd108747;  6'd32: raw = 20'd115213;  6'd33: raw = 20'd122064;
            6'd34: raw = 20'd129322;  6'd35: raw = 20'd137012;  6'd36: raw = 20'd145160;
            6'd37: raw = 20'd153791;  6'd38: raw = 20'd162936;  6'd39: raw = 20'd172625;
            6'd40: raw = 20'd182890;  6'd41: raw = 20'd193765;  6'd42: raw = 20'd205287;
            6'd43: raw = 20'd217494;  6'd44: raw = 20'd230426;  6'd45: raw = 20'd244128;
            6'd46: raw = 20'd258645;  6'd47: raw = 20'd274025;  6'd48: raw = 20'd290319;
            6'd49: raw = 20'd307582;  6'd50: raw = 20'd325872;  6'd51: raw = 20'd345249;
            6'd52: raw = 20'd365779;  6'd53: raw = 20'd387529;  6'd54: raw = 20'd410573;
            6'd55: raw = 20'd434987;  6'd56: raw = 20'd460853;  6'd57: raw = 20'd488256;
            6'd58: raw = 20'd517290;  6'd59: raw = 20'd548049;  6'd60: raw = 20'd580638;
            6'd61: raw = 20'd615165;  6'd62: raw = 20'd651744;  6'd63: raw = 20'd690499;
            default: raw = 20'd0;
        endcase
    end

    assign step_o = STEP_W'(raw);

endmodule

// File: rtl/note_player_new.sv
// Plays one note at a time: beat-counted duration, phase-accumulator waveform on codec request.
// Build option NOTE_PLAYER_DECAY_EN adds a per-beat amplitude decay (up to >>>4).
module note_player_new
    import note_player_pkg::*;
#(
    parameter int SAMPLE_W = note_player_pkg::SAMPLE_W,
    parameter int PHASE_W  = note_player_pkg::PHASE_W,
    parameter int STEP_W   = note_player_pkg::STEP_W,
    parameter int DUR_W    = note_player_pkg::DUR_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       play,
    input  logic [5:0]                 note,
    input  logic [DUR_W-1:0]           duration,
    input  logic [2:0]                 metadata,
    input  logic                       new_note,
    input  logic                       beat,
    input  logic                       generate_next_sample,
    output logic signed [SAMPLE_W-1:0] sample_out,
    output logic                       new_sample_ready,
    output logic                       note_done
);

    state_e                      state_q;
    logic [PHASE_W-1:0]          phase_q;
    logic [DUR_W-1:0]            remaining_q;
    logic [5:0]                  note_q;
    logic [1:0]                  wave_q;
    logic                        half_q;
    logic signed [SAMPLE_W-1:0]  sample_q;
    logic                        ready_q;
    logic                        done_q;

    logic [STEP_W-1:0]           step;
    logic [PHASE_W-1:0]          phase_inc;
    logic signed [15:0]          raw_s;
    logic signed [15:0]          half_s;
    logic signed [15:0]          shaped_s;
    logic signed [SAMPLE_W-1:0]  sample_d;
    logic                        take_req;
    logic                        count_beat;

    frequency_rom #(.STEP_W(STEP_W)) u_rom (
        .note_i (note_q),
        .step_o (step)
    );

    // Strobes: new_sample_ready and note_done are single-cycle registered pulses;
    // a request is answered exactly one cycle later, in IDLE always (with 0), in
    // ACTIVE only while play is high.
    assign take_req   = generate_next_sample && ((state_q == IDLE) || play);
    assign count_beat = (state_q == ACTIVE) && beat && play && !new_note;

    assign phase_inc = phase_q + PHASE_W'(step);
    assign raw_s     = (note_q == 6'd0) ? 16'sd0 : wave_sample(wave_q, phase_inc[PHASE_W-1 -: 16]);
    assign half_s    = half_q ? (raw_s >>> 1) : raw_s;

`ifdef NOTE_PLAYER_DECAY_EN
    logic [2:0] atten_q;

    always_ff @(posedge clk) begin
        if (reset || new_note) begin
            atten_q <= 3'd0;
        end else if (count_beat && (atten_q != 3'd4)) begin
            atten_q <= atten_q + 3'd1;
        end
    end

    assign shaped_s = half_s >>> atten_q;
`else
    assign shaped_s = half_s;
`endif

    assign sample_d = SAMPLE_W'(shaped_s);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            remaining_q <= '0;
            note_q      <= '0;
            wave_q      <= WAVE_SQUARE;
            half_q      <= 1'b0;
            sample_q    <= '0;
            ready_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            ready_q <= take_req;
            done_q  <= 1'b0;
            if (state_q == IDLE) begin
                sample_q <= '0;
            end else if (take_req) begin
                sample_q <= sample_d;
                phase_q  <= phase_inc;
            end
            // A new note overrides the current one, including its final beat.
            if (new_note) begin
                note_q      <= note;
                wave_q      <= metadata[1:0];
                half_q      <= metadata[2];
                phase_q     <= '0;
                remaining_q <= duration;
                if (duration == '0) begin
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                end else begin
                    state_q <= ACTIVE;
                end
            end else if (count_beat) begin
                remaining_q <= remaining_q - DUR_W'(1);
                if (remaining_q == DUR_W'(1)) begin
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                end
            end
        end
    end

    assign sample_out       = sample_q;
    assign new_sample_ready = ready_q;
    assign note_done        = done_q;

endmodule

// File: tb/tb_note_player_new.sv
// Randomized + directed bench for note_player_new against an arithmetic model of the
// note/beat/sample rules, with a per-cycle expected queue and literal pins.
module tb_note_player_new;

    logic        clk;
    logic        reset;
    logic        play;
    logic [5:0]  note;
    logic [5:0]  duration;
    logic [2:0]  metadata;
    logic        new_note;
    logic        beat;
    logic        generate_next_sample;
    logic signed [15:0] sample_out;
    logic        new_sample_ready;
    logic        note_done;

    int n_vec  = 0;
    int n_fail = 0;

    logic [17:0] exp_q[$];

    // model state
    bit m_active = 0;
    int m_phase  = 0;
    int m_rem    = 0;
    int m_note   = 0;
    int m_wave   = 0;
    int m_half   = 0;
    int m_atten  = 0;
    logic [15:0] m_sample = '0;

    int note_set[7] = '{0, 1, 13, 25, 37, 49, 61};

    note_player_new dut (
        .clk                  (clk),
        .reset                (reset),
        .play                 (play),
        .note                 (note),
        .duration             (duration),
        .metadata             (metadata),
        .new_note             (new_note),
        .beat                 (beat),
        .generate_next_sample (generate_next_sample),
        .sample_out           (sample_out),
        .new_sample_ready     (new_sample_ready),
        .note_done            (note_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int model_step(input int n);
        real f;
        if (n == 0) return 0;
        f = 440.0 * $pow(2.0, (n - 37) / 12.0);
        return $rtoi(f * 16777216.0 / 48000.0 + 0.5);
    endfunction

    function automatic int model_wave(input int wave, input int p);
        int u;
        case (wave)
            0: return (p < 32768) ? 16383 : -16384;
            1: return p - 32768;
            2: begin
                u = (p < 32768) ? p : 65535 - p;
                return 2 * u - 32768;
            end
            default: return 0;
        endcase
    endfunction

    // model: one expected {ready, done, sample} per clock
    always @(posedge clk) begin
        bit rdy;
        bit dn;
        int s;
        logic [15:0] smp;
        rdy = 0;
        dn  = 0;
        smp = m_sample;
        if (reset) begin
            m_active = 0; m_phase = 0; m_rem = 0; m_note = 0;
            m_wave = 0; m_half = 0; m_atten = 0; smp = '0;
        end else begin
            rdy = generate_next_sample && (!m_active || play);
            if (!m_active) begin
                smp = '0;
            end else if (rdy) begin
                m_phase = (m_phase + model_step(m_note)) % 16777216;
                s = (m_note == 0) ? 0 : model_wave(m_wave, m_phase / 256);
                if (m_half != 0) s = s >>> 1;
`ifdef NOTE_PLAYER_DECAY_EN
                s = s >>> m_atten;
`endif
                smp = s[15:0];
            end
            if (new_note) begin
                m_note = note; m_wave = metadata[1:0]; m_half = metadata[2];
                m_phase = 0; m_rem = duration; m_atten = 0;
                if (duration == 0) begin
                    dn = 1; m_active = 0;
                end else begin
                    m_active = 1;
                end
            end else if (m_active && beat && play) begin
                m_rem = m_rem - 1;
                if (m_atten < 4) m_atten = m_atten + 1;
                if (m_rem == 0) begin
                    dn = 1; m_active = 0;
                end
            end
        end
        m_sample = smp;
        exp_q.push_back({rdy, dn, smp});
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // compare process
    always @(negedge clk) begin
        logic [17:0] e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("ready", int'(new_sample_ready), int'(e[17]));
            check("done", int'(note_done), int'(e[16]));
            check("sample", int'(sample_out), int'($signed(e[15:0])));
        end
    end

    task automatic load(input int n, input int d, input int m);
        note     = 6'(n);
        duration = 6'(d);
        metadata = 3'(m);
    endtask

    task automatic tick(input bit nn, input bit bt, input bit gen);
        new_note = nn;
        beat = bt;
        generate_next_sample = gen;
        @(negedge clk);
        new_note = 1'b0;
        beat = 1'b0;
        generate_next_sample = 1'b0;
    endtask

    initial begin
        reset = 1'b1; play = 1'b0; note = '0; duration = '0; metadata = '0;
        new_note = 1'b0; beat = 1'b0; generate_next_sample = 1'b0;
        repeat (5) tick(0, 0, 0);
        check("rst_sample", int'(sample_out), 0);
        check("rst_ready", int'(new_sample_ready), 0);
        check("rst_done", int'(note_done), 0);
        reset = 1'b0;

        // idle requests answered with 0
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 1);
            check("idle_ready", int'(new_sample_ready), 1);
            check("idle_sample", int'(sample_out), 0);
            tick(0, 0, 0);
            check("idle_ready_low", int'(new_sample_ready), 0);
            check("idle_no_done", int'(note_done), 0);
        end

        // 3-beat note
        play = 1'b1;
        load(37, 3, 1);
        tick(1, 0, 0);
        tick(0, 1, 0);
        tick(0, 1, 0);
        check("dur3_early", int'(note_done), 0);
        tick(0, 1, 0);
        check("dur3_done", int'(note_done), 1);
        tick(0, 0, 0);
        check("dur3_done_low", int'(note_done), 0);
        tick(0, 0, 1);
        check("after_done_sample", int'(sample_out), 0);

        // back-to-back saw samples on note 37
        load(37, 8, 1);
        tick(1, 0, 0);
        tick(0, 0, 1); check("saw_1", int'(sample_out), -32168);
        tick(0, 0, 1); check("saw_2", int'(sample_out), -31567);
        tick(0, 0, 1); check("saw_3", int'(sample_out), -30966);
        tick(0, 0, 1); check("saw_4", int'(sample_out), -30366);
        check("saw_4_ready", int'(new_sample_ready), 1);
        repeat (7) tick(0, 1, 0);
        check("dur8_early", int'(note_done), 0);
        tick(0, 1, 0);
        check("dur8_done", int'(note_done), 1);

        // pause
        load(25, 3, 0);
        tick(1, 0, 0);
        tick(0, 1, 0);
        play = 1'b0;
        repeat (5) tick(0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 1);
            check("pause_ready", int'(new_sample_ready), 0);
        end
        play = 1'b1;
        tick(0, 1, 0);
        check("resume_early", int'(note_done), 0);
        tick(0, 1, 0);
        check("resume_done", int'(note_done), 1);

        // retrigger on final beat
        load(13, 2, 2);
        tick(1, 0, 0);
        tick(0, 1, 0);
        load(13, 4, 2);
        tick(1, 1, 0);
        check("retrig_no_done", int'(note_done), 0);
        repeat (3) tick(0, 1, 0);
        check("retrig_early", int'(note_done), 0);
        tick(0, 1, 0);
        check("retrig_done", int'(note_done), 1);

        // waveform literals via retriggers
        load(37, 1, 0); tick(1, 0, 0); tick(0, 0, 1);
        check("square", int'(sample_out), 16383);
        load(49, 1, 2); tick(1, 0, 0); tick(0, 0, 1);
        check("triangle", int'(sample_out), -30366);
        load(37, 1, 3); tick(1, 0, 0); tick(0, 0, 1);
        check("silent", int'(sample_out), 0);
        load(37, 1, 5); tick(1, 0, 0); tick(0, 0, 1);
        check("half_saw", int'(sample_out), -16084);
        tick(0, 1, 0);
        check("wave_done", int'(note_done), 1);

        // zero duration and rest
        load(37, 0, 0);
        tick(1, 0, 0);
        check("dur0_done", int'(note_done), 1);
        tick(0, 0, 0);
        check("dur0_done_low", int'(note_done), 0);
        load(0, 2, 1);
        tick(1, 0, 0);
        tick(0, 0, 1);
        check("rest_ready", int'(new_sample_ready), 1);
        check("rest_sample", int'(sample_out), 0);
        tick(0, 1, 0);
        tick(0, 1, 0);
        check("rest_done", int'(note_done), 1);

        // reset mid-note aborts silently
        load(37, 2, 1);
        tick(1, 0, 0);
        tick(0, 1, 0);
        reset = 1'b1;
        tick(0, 1, 0);
        check("rst_abort_done", int'(note_done), 0);
        reset = 1'b0;
        tick(0, 1, 0);
        tick(0, 1, 0);
        check("rst_abort_idle", int'(note_done), 0);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            bit nn;
            bit bt;
            bit gen;
            int r;
            r = $urandom_range(0, 199);
            play = ($urandom_range(0, 9) != 0);
            nn = (r < 8);
            if (nn) load(note_set[$urandom_range(0, 6)], $urandom_range(0, 7), $urandom_range(0, 7));
            gen = !nn && ($urandom_range(0, 2) == 0);
            bt = ($urandom_range(0, 5) == 0);
            reset = (r == 199);
            tick(nn, bt, gen);
            reset = 1'b0;
        end

        tick(0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
